// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state type, default sizes and rotating-priority pick helper
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 16;
  localparam int MAX_REQ = 32;
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    int idx;
    rr_pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + k >= n ? ptr + k - n : ptr + k;
      if (k < n) begin
        if (valid[idx]) begin
          rr_pick = '0;
          rr_pick[idx] = 1'b1;
        end
      end
    end
  endfunction
endpackage

// File: rtl/gcd_iter_core.sv
// gcd_iter_core: Euclid subtract-and-swap GCD engine, one step per clock
module gcd_iter_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] r_a, r_b;
  logic r_run;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      r_a <= '0;
      r_b <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_a <= a_in;
      r_b <= b_in;
    end else if (r_run) begin
      if (r_b == '0) begin
        r_run <= 1'b0;
      end else if (r_a < r_b) begin
        r_a <= r_b;
        r_b <= r_a;
      end else begin
        r_a <= r_a - r_b;
      end
    end
  end
  assign done = r_run && (r_b == '0);
  assign result = r_a;
endmodule

// File: rtl/gcd_share_ctrl.sv
// gcd_share_ctrl: round-robin sharing of one iterative GCD engine among N_REQ requesters
module gcd_share_ctrl
  import gcd_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   busy
);
  state_t r_state;
  logic [ID_W-1:0] r_ptr, w_gid, w_next;
  logic [N_REQ-1:0] w_pick;
  logic [WIDTH-1:0] w_a, w_b, w_result;
  logic w_fire, w_done;
  assign w_pick = N_REQ'(rr_pick(MAX_REQ'(req_valid), int'(r_ptr), N_REQ));
  assign req_ready = (r_state == IDLE) ? w_pick : '0;
  assign w_fire = |(req_valid & req_ready);
  always_comb begin
    w_gid = '0;
    for (int i = 0; i < N_REQ; i++) w_gid = req_ready[i] ? ID_W'(i) : w_gid;
  end
  assign w_next = (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
  assign w_a = req_a[w_gid*WIDTH +: WIDTH];
  assign w_b = req_b[w_gid*WIDTH +: WIDTH];
  gcd_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (w_fire),
    .a_in   (w_a),
    .b_in   (w_b),
    .done   (w_done),
    .result (w_result)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      busy <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_fire) begin
        r_state <= RUN;
        r_ptr <= w_next;
        rsp_id <= w_gid;
        busy <= 1'b1;
      end
    end else if (r_state == RUN) begin
      if (w_done) begin
        r_state <= DONE;
        rsp_valid <= 1'b1;
        rsp_result <= w_result;
      end
    end else if (rsp_ready) begin
      r_state <= IDLE;
      rsp_valid <= 1'b0;
      busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gcd_share_ctrl.sv
// tb_gcd_share_ctrl: directed and randomized checks of gcd_share_ctrl against a behavioural model
module tb_gcd_share_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0] req_ready;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [15:0] rsp_result;
  logic busy;
  int n_chk = 0;
  int n_err = 0;
  bit m_init = 0, m_busy = 0, m_valid = 0, m_rst_state = 0;
  int m_ptr = 0, m_cnt = 0, m_id = 0, m_res = 0, g_last = -1;
  int s_ready, s_valid, s_id, s_res, s_busy;
  int g_log[$];
  int r_log[$];
  gcd_share_ctrl #(.N_REQ(4), .WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  function automatic int steps_ref(input int a, input int b);
    int s = 0;
    int t;
    while (b != 0) begin
      if (a < b) begin
        t = a;
        a = b;
        b = t;
      end else a = a - b;
      s++;
    end
    return s;
  endfunction
  function automatic int pick(input logic [3:0] v, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction
  function automatic logic [15:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic check();
    int p;
    s_ready = int'(req_ready);
    s_valid = int'(rsp_valid);
    s_id = int'(rsp_id);
    s_res = int'(rsp_result);
    s_busy = int'(busy);
    if (!m_init) return;
    p = m_busy ? -1 : pick(req_valid, m_ptr);
    chk("req_ready", s_ready, p < 0 ? 0 : (1 << p));
    chk("rsp_valid", s_valid, int'(m_valid));
    chk("busy", s_busy, int'(m_busy));
    if (m_valid || m_rst_state) begin
      chk("rsp_id", s_id, m_valid ? m_id : 0);
      chk("rsp_result", s_res, m_valid ? m_res : 0);
    end
    for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) g_log.push_back(i);
    if (rsp_valid && rsp_ready) r_log.push_back(s_id * 65536 + s_res);
  endtask
  task automatic model_update();
    int p, a, b;
    g_last = -1;
    if (rst) begin
      m_init = 1;
      m_busy = 0;
      m_valid = 0;
      m_ptr = 0;
      m_rst_state = 1;
    end else if (m_init) begin
      if (!m_busy) begin
        p = pick(req_valid, m_ptr);
        if (p >= 0) begin
          a = int'(req_a[p*16 +: 16]);
          b = int'(req_b[p*16 +: 16]);
          m_busy = 1;
          m_id = p;
          m_res = gcd_ref(a, b);
          m_cnt = steps_ref(a, b) + 1;
          m_ptr = (p + 1) % 4;
          m_rst_state = 0;
          g_last = p;
        end
      end else if (!m_valid) begin
        m_cnt--;
        if (m_cnt == 0) m_valid = 1;
      end else if (rsp_ready) begin
        m_valid = 0;
        m_busy = 0;
      end
    end
  endtask
  task automatic step();
    #1;
    check();
    model_update();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask
  task automatic wait_rsp(input int max_n, output int n);
    n = 0;
    for (int k = 1; k <= max_n; k++) begin
      step();
      if (s_valid == 1 && rsp_ready) begin
        n = k;
        break;
      end
    end
    if (n == 0) chk("rsp_timeout", 0, 1);
  endtask
  task automatic run_single(input int id, input int a, input int b, input int res, input int lat);
    int n;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[id*16 +: 16] = 16'(a);
    req_b[id*16 +: 16] = 16'(b);
    rsp_ready = 1'b1;
    step();
    chk("single_grant", s_ready, 1 << id);
    req_valid = '0;
    wait_rsp(2000, n);
    chk("single_latency", n, lat);
    chk("single_result", s_res, res);
    chk("single_id", s_id, id);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, cnt1;
    int exp_g[5];
    int exp_r[4];
    bit pend[4];
    exp_g = '{0, 1, 2, 3, 0};
    exp_r = '{0*65536 + 4, 1*65536 + 5, 2*65536 + 7, 3*65536 + 3};
    @(negedge clk);
    do_reset();
    step();
    chk("reset_rsp_valid", s_valid, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_rsp_id", s_id, 0);
    chk("reset_rsp_result", s_res, 0);
    chk("reset_req_ready", s_ready, 0);
    run_single(0, 48, 18, 6, 10);
    run_single(1, 7, 0, 7, 2);
    run_single(1, 0, 9, 9, 3);
    run_single(1, 0, 0, 0, 2);
    do_reset();
    g_log.delete();
    r_log.delete();
    req_a = {16'd9, 16'd21, 16'd15, 16'd12};
    req_b = {16'd6, 16'd14, 16'd5, 16'd8};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 400 && g_log.size() < 5; k++) step();
    req_valid = '0;
    wait_rsp(200, n);
    chk("rr_grant_count", g_log.size(), 5);
    for (int k = 0; k < 5; k++) chk("rr_grant_order", k < g_log.size() ? g_log[k] : -1, exp_g[k]);
    for (int k = 0; k < 4; k++) chk("rr_id_result", k < r_log.size() ? r_log[k] : -1, exp_r[k]);
    do_reset();
    req_valid = 4'b0001;
    req_a[15:0] = 16'd5;
    req_b[15:0] = 16'd5;
    rsp_ready = 1'b0;
    step();
    chk("hold_grant", s_ready, 1);
    req_valid = 4'b0010;
    req_a[31:16] = 16'd8;
    req_b[31:16] = 16'd4;
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (s_valid == 1) begin
        n = k;
        break;
      end
    end
    chk("hold_latency", n, 4);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", s_valid, 1);
      chk("hold_id", s_id, 0);
      chk("hold_result", s_res, 5);
      chk("hold_no_grant", s_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("handshake_no_grant", s_ready, 0);
    step();
    chk("after_handshake_grant", s_ready, 4'b0010);
    req_valid = '0;
    wait_rsp(50, n);
    chk("hold_next_id", s_id, 1);
    chk("hold_next_result", s_res, 4);
    do_reset();
    req_valid = 4'b0001;
    req_a[15:0] = 16'd65535;
    req_b[15:0] = 16'd1;
    step();
    req_valid = '0;
    repeat (5) step();
    chk("midrun_busy", s_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_valid", s_valid, 0);
    chk("rst_mid_busy", s_busy, 0);
    chk("rst_mid_id", s_id, 0);
    chk("rst_mid_result", s_res, 0);
    req_a = '0;
    req_b = '0;
    req_valid = 4'hF;
    step();
    chk("rst_ptr_zero", s_ready, 1);
    req_valid = '0;
    wait_rsp(20, n);
    chk("rst_followup_id", s_id, 0);
    run_single(2, 100, 75, 25, 8);
    do_reset();
    r_log.delete();
    req_valid = 4'b0001;
    req_a[15:0] = 16'd48;
    req_b[15:0] = 16'd18;
    step();
    req_a[31:16] = 16'd10;
    req_b[31:16] = 16'd4;
    req_a[63:48] = 16'd9;
    req_b[63:48] = 16'd3;
    req_valid = 4'b1010;
    repeat (3) step();
    req_valid = 4'b1000;
    wait_rsp(50, n);
    step();
    chk("skip_dropped_grant", s_ready, 4'b1000);
    req_valid = '0;
    wait_rsp(50, n);
    chk("skip_id", s_id, 3);
    chk("skip_result", s_res, 3);
    cnt1 = 0;
    foreach (r_log[k]) if (r_log[k] / 65536 == 1) cnt1++;
    chk("skip_no_id1", cnt1, 0);
    do_reset();
    g_log.delete();
    for (int i = 0; i < 4; i++) pend[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (g_last == i) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          req_a[i*16 +: 16] = rnd_op();
          req_b[i*16 +: 16] = rnd_op();
        end else if (pend[i] && $urandom_range(0, 59) == 0) pend[i] = 0;
        req_valid[i] = pend[i];
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    chk("random_grants_seen", int'(g_log.size() > 20), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
